// File: rtl/decode_pkg.sv
// Shared pipeline constants for the decode stage.
// Opcodes, immediate formats and the canonical NOP.
package decode_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  function automatic imm_fmt_e imm_fmt(
    input logic [6:0] op
  );
    imm_fmt_e f;
    unique case (op)
      OP_LOAD,
      OP_IMM,
      OP_JALR,
      OP_SYSTEM: f = IMM_I;
      OP_STORE:  f = IMM_S;
      OP_BRANCH: f = IMM_B;
      OP_LUI,
      OP_AUIPC:  f = IMM_U;
      OP_JAL:    f = IMM_J;
      default:   f = IMM_NONE;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/decode_if.sv
// Decode-stage bundle: fetch in, writeback in,
// IF/ID and decoded fields out. master drives, slave is decode.
interface decode_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32
);

  logic                     stall_d;
  logic                     flush_d;
  logic [DATA_WIDTH-1:0]    instr_f;
  logic [ADDRESS_WIDTH-1:0] pc_f;
  logic [ADDRESS_WIDTH-1:0] pc_plus4_f;
  logic                     reg_write_w;
  logic [4:0]               rd_w;
  logic [DATA_WIDTH-1:0]    result_w;
  logic [DATA_WIDTH-1:0]    instr_d;
  logic [ADDRESS_WIDTH-1:0] pc_d;
  logic [ADDRESS_WIDTH-1:0] pc_plus4_d;
  logic                     valid_d;
  logic [4:0]               rs1_d;
  logic [4:0]               rs2_d;
  logic [4:0]               rd_d;
  logic [DATA_WIDTH-1:0]    rd1_d;
  logic [DATA_WIDTH-1:0]    rd2_d;
  logic [DATA_WIDTH-1:0]    imm_ext_d;

  modport master (
    output stall_d, flush_d,
    output instr_f, pc_f, pc_plus4_f,
    output reg_write_w, rd_w, result_w,
    input  instr_d, pc_d, pc_plus4_d, valid_d,
    input  rs1_d, rs2_d, rd_d,
    input  rd1_d, rd2_d, imm_ext_d
  );

  modport slave (
    input  stall_d, flush_d,
    input  instr_f, pc_f, pc_plus4_f,
    input  reg_write_w, rd_w, result_w,
    output instr_d, pc_d, pc_plus4_d, valid_d,
    output rs1_d, rs2_d, rd_d,
    output rd1_d, rd2_d, imm_ext_d
  );

endinterface

// File: rtl/decode_reg_file.sv
// 32-entry register file, x0 hardwired to zero,
// two async read ports with write-first bypass.
module reg_file #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [4:0]            waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [4:0]            ra1,
  input  logic [4:0]            ra2,
  output logic [DATA_WIDTH-1:0] rd1,
  output logic [DATA_WIDTH-1:0] rd2
);

  logic [DATA_WIDTH-1:0] regs [32];
  logic                  wr_ok;

  assign wr_ok = we && (waddr != 5'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_ok) begin
      regs[waddr] <= wdata;
    end
  end

  function automatic logic [DATA_WIDTH-1:0] rd_port(
    input logic [4:0] ra
  );
    logic [DATA_WIDTH-1:0] v;
    unique case (1'b1)
      (ra == 5'd0):             v = '0;
      (wr_ok && ra == waddr):   v = wdata;
      default:                  v = regs[ra];
    endcase
    return v;
  endfunction

  assign rd1 = rd_port(ra1);
  assign rd2 = rd_port(ra2);

endmodule

// File: rtl/decode.sv
// Decode stage: IF/ID register, field extract,
// register file reads and immediate generation.
module decode
  import decode_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32
) (
  input logic   clk,
  input logic   rst,
  decode_if.slave bus
);

  logic [DATA_WIDTH-1:0]    instr_q;
  logic [ADDRESS_WIDTH-1:0] pc_q;
  logic [ADDRESS_WIDTH-1:0] pc4_q;
  logic                     valid_q;

  // flush outranks stall so a squashed slot never sticks
  always_ff @(posedge clk) begin
    if (rst || bus.flush_d) begin
      instr_q <= DATA_WIDTH'(NOP_INSTR);
      pc_q    <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else if (!bus.stall_d) begin
      instr_q <= bus.instr_f;
      pc_q    <= bus.pc_f;
      pc4_q   <= bus.pc_plus4_f;
      valid_q <= 1'b1;
    end
  end

  assign bus.instr_d    = instr_q;
  assign bus.pc_d       = pc_q;
  assign bus.pc_plus4_d = pc4_q;
  assign bus.valid_d    = valid_q;

  assign bus.rs1_d = instr_q[19:15];
  assign bus.rs2_d = instr_q[24:20];
  assign bus.rd_d  = instr_q[11:7];

  reg_file #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rf (
    .clk   (clk),
    .rst   (rst),
    .we    (bus.reg_write_w),
    .waddr (bus.rd_w),
    .wdata (bus.result_w),
    .ra1   (instr_q[19:15]),
    .ra2   (instr_q[24:20]),
    .rd1   (bus.rd1_d),
    .rd2   (bus.rd2_d)
  );

  imm_fmt_e    fmt;
  logic [31:0] ins;
  logic [31:0] imm32;

  assign ins = instr_q[31:0];
  assign fmt = imm_fmt(ins[6:0]);

  always_comb begin
    imm32 = '0;
    unique case (fmt)
      IMM_I: imm32 = {{20{ins[31]}}, ins[31:20]};
      IMM_S: imm32 = {{20{ins[31]}},
                      ins[31:25], ins[11:7]};
      IMM_B: imm32 = {{19{ins[31]}}, ins[31],
                      ins[7], ins[30:25],
                      ins[11:8], 1'b0};
      IMM_U: imm32 = {ins[31:12], 12'b0};
      IMM_J: imm32 = {{11{ins[31]}}, ins[31],
                      ins[19:12], ins[20],
                      ins[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // sign-extend the 32-bit immediate to the datapath width
  assign bus.imm_ext_d = DATA_WIDTH'($signed(imm32));

endmodule

// File: tb/tb_decode.sv
// Directed bench for decode: IF/ID control,
// register file, bypass and immediates.
module tb_decode;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  decode_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32)) bus ();

  decode #(
    .DATA_WIDTH    (32),
    .ADDRESS_WIDTH (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] imm_in  [8];
  logic [31:0] imm_exp [8];

  initial begin
    total = 0;
    bad   = 0;
    imm_in[0] = 32'hFE000EE3; imm_exp[0] = 32'hFFFFFFFC;
    imm_in[1] = 32'h123452B7; imm_exp[1] = 32'h12345000;
    imm_in[2] = 32'h0080006F; imm_exp[2] = 32'h00000008;
    imm_in[3] = 32'h00112623; imm_exp[3] = 32'h0000000C;
    imm_in[4] = 32'hFE112E23; imm_exp[4] = 32'hFFFFFFFC;
    imm_in[5] = 32'h00A00513; imm_exp[5] = 32'h0000000A;
    imm_in[6] = 32'hFFFFF517; imm_exp[6] = 32'hFFFFF000;
    imm_in[7] = 32'h0000007F; imm_exp[7] = 32'h00000000;

    rst             = 1'b1;
    bus.stall_d     = 1'b0;
    bus.flush_d     = 1'b0;
    bus.instr_f     = 32'h00000013;
    bus.pc_f        = '0;
    bus.pc_plus4_f  = '0;
    bus.reg_write_w = 1'b0;
    bus.rd_w        = '0;
    bus.result_w    = '0;
    tick();
    check("rst_instr", bus.instr_d, 32'h00000013);
    check("rst_valid", 32'(bus.valid_d), 32'd0);
    check("rst_pc", bus.pc_d, 32'd0);
    check("rst_pc4", bus.pc_plus4_d, 32'd0);

    // seed x7, then try writing x8 on a reset edge
    rst = 1'b0;
    bus.reg_write_w = 1'b1;
    bus.rd_w = 5'd7;
    bus.result_w = 32'hAAAA5555;
    tick();
    rst = 1'b1;
    bus.rd_w = 5'd8;
    bus.result_w = 32'h12345678;
    tick();
    rst = 1'b0;
    bus.reg_write_w = 1'b0;

    for (int i = 0; i < 32; i++) begin
      bus.instr_f = {7'd0, 5'(i), 5'(i), 3'd0,
                     5'd0, 7'b0110011};
      tick();
      check($sformatf("rst_rd1_x%0d", i), bus.rd1_d, 32'd0);
      check($sformatf("rst_rd2_x%0d", i), bus.rd2_d, 32'd0);
    end
    check("r_rs1", 32'(bus.rs1_d), 32'd31);
    check("r_imm", bus.imm_ext_d, 32'd0);

    bus.pc_f = 32'h10;
    bus.pc_plus4_f = 32'h14;
    bus.instr_f = 32'hFFF00093;
    tick();
    check("addi_instr", bus.instr_d, 32'hFFF00093);
    check("addi_pc", bus.pc_d, 32'h10);
    check("addi_pc4", bus.pc_plus4_d, 32'h14);
    check("addi_valid", 32'(bus.valid_d), 32'd1);
    check("addi_rd", 32'(bus.rd_d), 32'd1);
    check("addi_imm", bus.imm_ext_d, 32'hFFFFFFFF);

    bus.stall_d = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.instr_f = 32'h00500193 + 32'(i << 7);
      bus.pc_f = 32'h20 + 32'(i * 4);
      tick();
      check("stall_instr", bus.instr_d, 32'hFFF00093);
      check("stall_pc", bus.pc_d, 32'h10);
      check("stall_valid", 32'(bus.valid_d), 32'd1);
    end

    bus.flush_d = 1'b1;
    tick();
    check("flush_instr", bus.instr_d, 32'h00000013);
    check("flush_valid", 32'(bus.valid_d), 32'd0);
    check("flush_pc", bus.pc_d, 32'd0);
    bus.flush_d = 1'b0;
    bus.stall_d = 1'b0;

    // add x3,x5,x6
    bus.instr_f = 32'h006281B3;
    tick();
    bus.reg_write_w = 1'b1;
    bus.rd_w = 5'd5;
    bus.result_w = 32'hDEADBEEF;
    #1;
    check("bypass_rd1", bus.rd1_d, 32'hDEADBEEF);
    check("bypass_rd2", bus.rd2_d, 32'd0);
    tick();
    bus.reg_write_w = 1'b0;
    #1;
    check("stored_x5", bus.rd1_d, 32'hDEADBEEF);

    // add x3,x5,x0 with a write aimed at x0
    bus.instr_f = 32'h000281B3;
    bus.reg_write_w = 1'b1;
    bus.rd_w = 5'd0;
    bus.result_w = 32'h1234;
    tick();
    check("x0_bypass", bus.rd2_d, 32'd0);
    bus.reg_write_w = 1'b0;
    tick();
    check("x0_stored", bus.rd2_d, 32'd0);

    for (int i = 0; i < 8; i++) begin
      bus.instr_f = imm_in[i];
      tick();
      check($sformatf("imm_%h", imm_in[i]),
            bus.imm_ext_d, imm_exp[i]);
    end

    // held rs1=x5 must see a writeback during stall
    bus.instr_f = 32'h006281B3;
    tick();
    bus.stall_d = 1'b1;
    bus.instr_f = 32'h00A00513;
    bus.reg_write_w = 1'b1;
    bus.rd_w = 5'd5;
    bus.result_w = 32'h00000055;
    tick();
    bus.reg_write_w = 1'b0;
    #1;
    check("stall_wb_rd1", bus.rd1_d, 32'h55);
    check("stall_wb_instr", bus.instr_d, 32'h006281B3);

    // reset during stall wins and clears x5
    rst = 1'b1;
    tick();
    check("rst_stall_instr", bus.instr_d, 32'h00000013);
    check("rst_stall_valid", 32'(bus.valid_d), 32'd0);
    rst = 1'b0;
    bus.stall_d = 1'b0;
    bus.instr_f = 32'h006281B3;
    bus.pc_f = 32'h40;
    bus.pc_plus4_f = 32'h44;
    tick();
    check("post_rst_pc", bus.pc_d, 32'h40);
    check("post_rst_valid", 32'(bus.valid_d), 32'd1);
    check("post_rst_x5", bus.rd1_d, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
